// File: rtl/stream_pattern_gen.sv
// AXI-Stream packet generator: counter, constant, LFSR and walking-one patterns with throttle/gap pacing.
// Define PATTERN_GEN_LFSR_EN to build the 32-bit LFSR for mode 2; otherwise mode 2 acts as counter.
module stream_pattern_gen #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16,
   parameter int THR_W  = 5
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              enable,
   input  logic [1:0]        cfg_mode,
   input  logic [LEN_W-1:0]  cfg_pkt_len,
   input  logic [LEN_W-1:0]  cfg_gap,
   input  logic [THR_W-1:0]  cfg_throttle,
   input  logic [DATA_W-1:0] cfg_seed,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic [31:0]       pkt_count
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_e;

   localparam int CNT_W = (LEN_W > THR_W) ? LEN_W : THR_W;
   localparam int CW    = (DATA_W < 32) ? DATA_W : 32;

   state_e             state_q, state_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic               busy_q;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   gap_q, gap_d;
   logic [THR_W-1:0]   thr_q, thr_d;
   logic [1:0]         mode_q, mode_d;
   logic [CNT_W-1:0]   wait_q, wait_d;
   logic [31:0]        pkt_q, pkt_d;

   logic               accept_s;
   logic               last_beat_s;
   logic               wait_done_s;
   logic               relatch_s;
   logic               load_s;
   logic [LEN_W-1:0]   len_eff_s;
   logic [DATA_W-1:0]  pat_nxt_s;
   logic [DATA_W-1:0]  pat_load_s;

`ifdef PATTERN_GEN_LFSR_EN
   logic [31:0]        lfsr_q, lfsr_d;
   logic [31:0]        lfsr_nxt_s;
   logic [31:0]        seed32_s;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
   endfunction

   assign lfsr_nxt_s = lfsr_step(lfsr_q);
   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   assign seed32_s   = (cfg_seed[CW-1:0] == {CW{1'b0}}) ? 32'd1 : 32'(cfg_seed[CW-1:0]);
`endif

   assign accept_s    = valid_q & m_ready;
   assign last_beat_s = accept_s & last_q;
   assign wait_done_s = (wait_q <= CNT_W'(1));
   assign len_eff_s   = (cfg_pkt_len == {LEN_W{1'b0}}) ? LEN_W'(1) : cfg_pkt_len;
   assign relatch_s   = (state_d == S_SEND) && ((state_q != S_SEND) || last_beat_s);
   assign load_s      = (state_q == S_IDLE) && (state_d == S_SEND);

   // Pattern value after an accepted beat, and the value loaded when leaving IDLE.
   always_comb begin
      pat_nxt_s  = data_q;
      pat_load_s = cfg_seed;
      case (mode_q)
         2'd0:    pat_nxt_s = data_q + DATA_W'(1);
         2'd1:    pat_nxt_s = data_q;
`ifdef PATTERN_GEN_LFSR_EN
         2'd2:    pat_nxt_s = DATA_W'(lfsr_nxt_s[CW-1:0]);
`else
         2'd2:    pat_nxt_s = data_q + DATA_W'(1);
`endif
         2'd3:    pat_nxt_s = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
         default: pat_nxt_s = data_q;
      endcase
      case (cfg_mode)
         2'd3:    pat_load_s = DATA_W'(1);
`ifdef PATTERN_GEN_LFSR_EN
         2'd2:    pat_load_s = DATA_W'(seed32_s[CW-1:0]);
`endif
         default: pat_load_s = cfg_seed;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_SEND;
            else        state_d = S_IDLE;
         end
         S_SEND: begin
            if (last_beat_s) begin
               if (!enable)                      state_d = S_IDLE;
               else if (gap_q == {LEN_W{1'b0}})  state_d = S_SEND;
               else                              state_d = S_GAP;
            end else begin
               state_d = S_SEND;
            end
         end
         S_GAP: begin
            if (wait_done_s) state_d = enable ? S_SEND : S_IDLE;
            else             state_d = S_GAP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the stream outputs, counters and latched configuration.
   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      beat_d  = beat_q;
      len_d   = len_q;
      gap_d   = gap_q;
      thr_d   = thr_q;
      mode_d  = mode_q;
      wait_d  = wait_q;
      pkt_d   = pkt_q;
`ifdef PATTERN_GEN_LFSR_EN
      lfsr_d  = lfsr_q;
`endif
      if (accept_s) begin
         data_d = pat_nxt_s;
`ifdef PATTERN_GEN_LFSR_EN
         if (mode_q == 2'd2) lfsr_d = lfsr_nxt_s;
         else                lfsr_d = lfsr_q;
`endif
         if (last_q) begin
            pkt_d   = pkt_q + 32'd1;
            beat_d  = {LEN_W{1'b0}};
            valid_d = 1'b0;
            last_d  = 1'b0;
            wait_d  = CNT_W'(gap_q);
         end else begin
            beat_d = beat_q + LEN_W'(1);
            if (thr_q == {THR_W{1'b0}}) begin
               valid_d = 1'b1;
               last_d  = ((beat_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
            end else begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               wait_d  = CNT_W'(thr_q);
            end
         end
      end else if ((state_q == S_SEND) && !valid_q) begin
         if (wait_done_s) begin
            valid_d = 1'b1;
            last_d  = (beat_q == (len_q - LEN_W'(1)));
            wait_d  = {CNT_W{1'b0}};
         end else begin
            wait_d = wait_q - CNT_W'(1);
         end
      end else if (state_q == S_GAP) begin
         if (wait_done_s) wait_d = {CNT_W{1'b0}};
         else             wait_d = wait_q - CNT_W'(1);
      end else begin
         wait_d = wait_q;
      end
      if (relatch_s) begin
         len_d   = len_eff_s;
         gap_d   = cfg_gap;
         thr_d   = cfg_throttle;
         mode_d  = cfg_mode;
         beat_d  = {LEN_W{1'b0}};
         valid_d = 1'b1;
         last_d  = (len_eff_s == LEN_W'(1));
         wait_d  = {CNT_W{1'b0}};
      end else begin
         len_d = len_d;
      end
      if (load_s) begin
         data_d = pat_load_s;
`ifdef PATTERN_GEN_LFSR_EN
         lfsr_d = seed32_s;
`endif
      end else begin
         data_d = data_d;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= {DATA_W{1'b0}};
         beat_q  <= {LEN_W{1'b0}};
         len_q   <= {LEN_W{1'b0}};
         gap_q   <= {LEN_W{1'b0}};
         thr_q   <= {THR_W{1'b0}};
         mode_q  <= 2'd0;
         wait_q  <= {CNT_W{1'b0}};
         pkt_q   <= 32'd0;
`ifdef PATTERN_GEN_LFSR_EN
         lfsr_q  <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= (state_d != S_IDLE);
         data_q  <= data_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         thr_q   <= thr_d;
         mode_q  <= mode_d;
         wait_q  <= wait_d;
         pkt_q   <= pkt_d;
`ifdef PATTERN_GEN_LFSR_EN
         lfsr_q  <= lfsr_d;
`endif
      end
   end

   assign m_valid   = valid_q;
   assign m_last    = last_q;
   assign m_data    = data_q;
   assign busy      = busy_q;
   assign pkt_count = pkt_q;

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed self-checking bench for stream_pattern_gen (default parameters).
module tb_stream_pattern_gen;

   logic        clk;
   logic        aresetn;
   logic        enable;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_pkt_len;
   logic [15:0] cfg_gap;
   logic [4:0]  cfg_throttle;
   logic [31:0] cfg_seed;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;
   logic        busy;
   logic [31:0] pkt_count;

   int chk_total;
   int chk_pass;

   stream_pattern_gen #(.DATA_W(32), .LEN_W(16), .THR_W(5)) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .enable       (enable),
      .cfg_mode     (cfg_mode),
      .cfg_pkt_len  (cfg_pkt_len),
      .cfg_gap      (cfg_gap),
      .cfg_throttle (cfg_throttle),
      .cfg_seed     (cfg_seed),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .busy         (busy),
      .pkt_count    (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_total++;
      if (got === exp) chk_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_cfg(input logic [1:0] mode, input logic [15:0] len, input logic [15:0] gap,
                          input logic [4:0] thr, input logic [31:0] seed);
      cfg_mode     = mode;
      cfg_pkt_len  = len;
      cfg_gap      = gap;
      cfg_throttle = thr;
      cfg_seed     = seed;
   endtask

   logic [19:0] vmask;
   logic        ok;
   logic [31:0] lfsr_exp [4];

   initial begin
      chk_total = 0;
      chk_pass  = 0;
      aresetn   = 1'b0;
      enable    = 1'b0;
      m_ready   = 1'b1;
      set_cfg(2'd0, 16'd4, 16'd0, 5'd0, 32'h10);
`ifdef PATTERN_GEN_LFSR_EN
      lfsr_exp[0] = 32'h1; lfsr_exp[1] = 32'h3; lfsr_exp[2] = 32'h6; lfsr_exp[3] = 32'hD;
`else
      lfsr_exp[0] = 32'h0; lfsr_exp[1] = 32'h1; lfsr_exp[2] = 32'h2; lfsr_exp[3] = 32'h3;
`endif
      tick(); tick();
      check_eq("rst_valid", 64'(m_valid), 64'd0);
      check_eq("rst_last", 64'(m_last), 64'd0);
      check_eq("rst_data", 64'(m_data), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_pkt", 64'(pkt_count), 64'd0);
      aresetn = 1'b1;
      tick(); tick();
      check_eq("idle_hold_busy", 64'(busy), 64'd0);
      check_eq("idle_hold_valid", 64'(m_valid), 64'd0);

      // Counter mode: two back-to-back packets of 4.
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq($sformatf("cnt_valid%0d", i), 64'(m_valid), 64'd1);
         check_eq($sformatf("cnt_data%0d", i), 64'(m_data), 64'(32'h10 + i));
         check_eq($sformatf("cnt_last%0d", i), 64'(m_last), 64'((i % 4) == 3));
      end
      enable = 1'b0;
      tick();
      check_eq("cnt_pkt", 64'(pkt_count), 64'd2);
      check_eq("cnt_idle_valid", 64'(m_valid), 64'd0);
      check_eq("cnt_idle_busy", 64'(busy), 64'd0);

      // Throttle 2 and gap 5.
      set_cfg(2'd0, 16'd3, 16'd5, 5'd2, 32'h0);
      enable = 1'b1;
      vmask  = 20'd0;
      for (int k = 1; k < 20; k++) begin
         tick();
         vmask[k] = m_valid;
      end
      check_eq("thr_gap_mask", 64'(vmask), 64'h92092);
      check_eq("thr_gap_data", 64'(m_data), 64'd5);
      check_eq("thr_gap_last", 64'(m_last), 64'd1);
      check_eq("thr_gap_busy", 64'(busy), 64'd1);
      enable = 1'b0;
      tick();
      check_eq("thr_gap_pkt", 64'(pkt_count), 64'd4);

      // Backpressure in walking-one mode.
      set_cfg(2'd3, 16'd4, 16'd0, 5'd0, 32'hFFFF);
      enable = 1'b1;
      tick();
      check_eq("walk_b0", 64'(m_data), 64'h1);
      tick();
      check_eq("walk_b1", 64'(m_data), 64'h2);
      tick();
      check_eq("walk_b2", 64'(m_data), 64'h4);
      enable  = 1'b0;
      m_ready = 1'b0;
      ok      = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (!(m_valid === 1'b1 && m_data === 32'h4 && m_last === 1'b0)) ok = 1'b0;
      end
      check_eq("walk_stall_stable", 64'(ok), 64'd1);
      m_ready = 1'b1;
      tick();
      check_eq("walk_b3", 64'(m_data), 64'h8);
      check_eq("walk_b3_last", 64'(m_last), 64'd1);
      tick();
      check_eq("walk_pkt", 64'(pkt_count), 64'd5);

      // Enable dropped on beat 1 of an 8-beat packet.
      set_cfg(2'd0, 16'd8, 16'd0, 5'd0, 32'h100);
      enable = 1'b1;
      tick();
      tick();
      check_eq("drop_b1", 64'(m_data), 64'h101);
      enable = 1'b0;
      ok     = 1'b1;
      for (int i = 2; i < 8; i++) begin
         tick();
         if (!(m_valid === 1'b1 && m_data === (32'h100 + 32'(i)) && m_last === (i == 7))) ok = 1'b0;
      end
      check_eq("drop_beats", 64'(ok), 64'd1);
      tick();
      check_eq("drop_valid", 64'(m_valid), 64'd0);
      check_eq("drop_busy", 64'(busy), 64'd0);
      check_eq("drop_pkt", 64'(pkt_count), 64'd6);

      // Reset asserted on beat 2, then restart from seed.
      set_cfg(2'd0, 16'd4, 16'd0, 5'd0, 32'h20);
      enable = 1'b1;
      tick(); tick(); tick();
      check_eq("rstm_b2", 64'(m_data), 64'h22);
      aresetn = 1'b0;
      #1;
      check_eq("rstm_valid", 64'(m_valid), 64'd0);
      check_eq("rstm_last", 64'(m_last), 64'd0);
      check_eq("rstm_pkt", 64'(pkt_count), 64'd0);
      tick();
      aresetn = 1'b1;
      tick();
      check_eq("rstm_restart", 64'(m_data), 64'h20);
      check_eq("rstm_restart_valid", 64'(m_valid), 64'd1);
      enable = 1'b0;
      tick(); tick(); tick();
      check_eq("rstm_restart_last", 64'(m_last), 64'd1);
      tick();
      check_eq("rstm_restart_pkt", 64'(pkt_count), 64'd1);

      // Mode 2 with zero seed.
      set_cfg(2'd2, 16'd4, 16'd0, 5'd0, 32'h0);
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq($sformatf("lfsr_data%0d", i), 64'(m_data), 64'(lfsr_exp[i]));
         if (i == 3) enable = 1'b0;
      end
      check_eq("lfsr_last", 64'(m_last), 64'd1);
      tick();
      check_eq("lfsr_pkt", 64'(pkt_count), 64'd2);

      // Constant mode, length 0 means 1, seed change after latch ignored.
      set_cfg(2'd1, 16'd0, 16'd0, 5'd0, 32'hA5);
      enable = 1'b1;
      tick();
      check_eq("const_data0", 64'(m_data), 64'hA5);
      check_eq("const_last0", 64'(m_last), 64'd1);
      cfg_seed = 32'h5A;
      tick();
      check_eq("const_data1", 64'(m_data), 64'hA5);
      check_eq("const_last1", 64'(m_last), 64'd1);
      enable = 1'b0;
      tick();
      check_eq("const_pkt", 64'(pkt_count), 64'd4);
      check_eq("const_busy", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

endmodule
